// File: rtl/tone_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_scan_controller_pkg
// Description : Direction codes, controller state encoding and button map.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_scan_controller_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t DIR_NONE  = 3'd0;
    localparam dir_t DIR_FWD   = 3'd1;
    localparam dir_t DIR_LEFT  = 3'd2;
    localparam dir_t DIR_RIGHT = 3'd3;
    localparam dir_t DIR_BACK  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WINDOW   = 3'd1,
        ST_GAP      = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    // Index 0 is pushBtn1.
    localparam dir_t BTN_DIR [4] = '{DIR_FWD, DIR_LEFT, DIR_RIGHT, DIR_BACK};

    // Codes above DIR_BACK carry no direction.
    function automatic dir_t dirSanitize(input logic [2:0] raw);
        return (raw > DIR_BACK) ? DIR_NONE : dir_t'(raw);
    endfunction

    // Lowest-index button wins when several rise together.
    function automatic dir_t btnToDir(input logic [3:0] rises);
        dir_t d;
        d = DIR_NONE;
        for (int i = 3; i >= 0; i--) begin
            if (rises[i]) begin
                d = BTN_DIR[i];
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : tone_scan_controller_if
// Description : Valid/ready direction command channel to the drive logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface tone_scan_controller_if;
    import tone_scan_controller_pkg::*;

    dir_t cmdDir;
    logic cmdValid;
    logic cmdReady;

    modport master (output cmdDir, output cmdValid, input cmdReady);
    modport slave  (input cmdDir, input cmdValid, output cmdReady);

endinterface
`default_nettype wire

// File: rtl/tone_scan_controller_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronises one raw button, filters it, emits level + rise.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic btnRaw,
    output logic      btnLevel,
    output logic      btnRise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] c_last = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // The level only follows the input after it has disagreed for the full count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btnRaw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_last) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign btnLevel = r_level;
    assign btnRise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/tone_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tone_scan_controller
// Description : Windows ToneDetection, votes on results, issues drive commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_scan_controller
    import tone_scan_controller_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 25000000,
    parameter int VOTE_COUNT      = 3,
    parameter int MAX_WINDOWS     = 8,
    parameter int COOLDOWN_CYCLES = 12500000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              scanEnable,
    input  wire logic [3:0]        pushBtn,
    input  wire logic [2:0]        toneDir,
    output logic                   enableToneDetection,
    output logic                   busy,
    output logic                   noTone,
    tone_scan_controller_if.master cmdBus
);

    localparam int CNT_MAX = (WINDOW_CYCLES > COOLDOWN_CYCLES) ? WINDOW_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AGREE_W = $clog2(VOTE_COUNT + 1);
    localparam int USED_W  = $clog2(MAX_WINDOWS + 1);

    localparam logic [CNT_W-1:0]   c_winLast  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_coolLast = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [AGREE_W-1:0] c_votes    = AGREE_W'(VOTE_COUNT);
    localparam logic [USED_W-1:0]  c_maxWin   = USED_W'(MAX_WINDOWS);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [AGREE_W-1:0] r_agree;
    logic [USED_W-1:0]  r_used;
    dir_t               r_prevDir;
    logic               r_pendValid;
    dir_t               r_pendDir;
    logic               r_enable;
    logic               r_cmdValid;
    dir_t               r_cmdDir;
    logic               r_busy;
    logic               r_noTone;

    logic [3:0]         w_btnRise;
    logic [3:0]         w_unusedLevel;
    logic               w_press;
    dir_t               w_pressDir;
    dir_t               w_tone;
    logic [AGREE_W-1:0] w_agreeNext;
    logic [USED_W-1:0]  w_usedNext;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .btnRaw  (pushBtn[i]),
                .btnLevel(w_unusedLevel[i]),
                .btnRise (w_btnRise[i])
            );
        end
    endgenerate

    assign w_press    = |w_btnRise;
    assign w_pressDir = btnToDir(w_btnRise);
    assign w_tone     = dirSanitize(toneDir);
    assign w_usedNext = r_used + 1'b1;

    always_comb begin
        w_agreeNext = '0;
        if (w_tone != DIR_NONE && w_tone == r_prevDir) begin
            w_agreeNext = r_agree + 1'b1;
        end else if (w_tone != DIR_NONE) begin
            w_agreeNext = AGREE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_agree     <= '0;
            r_used      <= '0;
            r_prevDir   <= DIR_NONE;
            r_pendValid <= 1'b0;
            r_pendDir   <= DIR_NONE;
            r_enable    <= 1'b0;
            r_cmdValid  <= 1'b0;
            r_cmdDir    <= DIR_NONE;
            r_busy      <= 1'b0;
            r_noTone    <= 1'b0;
        end else begin
            r_noTone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state     <= ST_ISSUE;
                        r_cmdValid  <= 1'b1;
                        r_cmdDir    <= w_pressDir;
                        r_busy      <= 1'b1;
                        r_pendValid <= 1'b0;
                    end else if (r_pendValid) begin
                        r_state     <= ST_ISSUE;
                        r_cmdValid  <= 1'b1;
                        r_cmdDir    <= r_pendDir;
                        r_busy      <= 1'b1;
                        r_pendValid <= 1'b0;
                    end else if (scanEnable) begin
                        r_state   <= ST_WINDOW;
                        r_enable  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_agree   <= '0;
                        r_used    <= '0;
                        r_prevDir <= DIR_NONE;
                    end
                end

                ST_WINDOW: begin
                    if (w_press) begin
                        r_state    <= ST_ISSUE;
                        r_enable   <= 1'b0;
                        r_cmdValid <= 1'b1;
                        r_cmdDir   <= w_pressDir;
                    end else if (!scanEnable) begin
                        r_state  <= ST_IDLE;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (r_cnt == c_winLast) begin
                        // Last enabled cycle: toneDir is valid now.
                        r_cnt    <= '0;
                        r_enable <= 1'b0;
                        r_agree  <= w_agreeNext;
                        if (w_tone != DIR_NONE) begin
                            r_prevDir <= w_tone;
                        end
                        if (w_agreeNext >= c_votes) begin
                            r_state    <= ST_ISSUE;
                            r_cmdValid <= 1'b1;
                            r_cmdDir   <= w_tone;
                        end else begin
                            r_used <= w_usedNext;
                            if (w_usedNext == c_maxWin) begin
                                r_state    <= ST_ISSUE;
                                r_cmdValid <= 1'b1;
                                r_cmdDir   <= DIR_NONE;
                                r_noTone   <= 1'b1;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (w_press) begin
                        r_state    <= ST_ISSUE;
                        r_cmdValid <= 1'b1;
                        r_cmdDir   <= w_pressDir;
                    end else if (!scanEnable) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state  <= ST_WINDOW;
                        r_enable <= 1'b1;
                        r_cnt    <= '0;
                    end
                end

                ST_ISSUE: begin
                    // The in-flight command is never touched by a press.
                    if (w_press) begin
                        r_pendValid <= 1'b1;
                        r_pendDir   <= w_pressDir;
                    end
                    if (r_cmdValid && cmdBus.cmdReady) begin
                        r_state    <= ST_COOLDOWN;
                        r_cmdValid <= 1'b0;
                        r_cmdDir   <= DIR_NONE;
                        r_cnt      <= '0;
                    end
                end

                ST_COOLDOWN: begin
                    if (w_press) begin
                        r_pendValid <= 1'b1;
                        r_pendDir   <= w_pressDir;
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                    end else if (r_cnt == c_coolLast) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_enable   <= 1'b0;
                    r_cmdValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign enableToneDetection = r_enable;
    assign busy                = r_busy;
    assign noTone              = r_noTone;
    assign cmdBus.cmdValid     = r_cmdValid;
    assign cmdBus.cmdDir       = r_cmdDir;

endmodule
`default_nettype wire

// File: doc/tone_scan_controller.md
Name: tone_scan_controller

Overview:
- Sequences the ToneDetection block in repeated detection windows.
- Drives its enableToneDetection input and samples its 3-bit toneDir result at the end of each window.
- Votes on consecutive results and issues one debounced, handshaked direction command to the drive logic.
- Push buttons 1-4 give a manual direction override that pre-empts scanning.

Parameters:
- WINDOW_CYCLES, 25000000: cycles enableToneDetection stays high per window (1 s at 25 MHz).
- VOTE_COUNT, 3: consecutive identical nonzero samples required to issue a command.
- MAX_WINDOWS, 8: windows allowed per scan before giving up.
- COOLDOWN_CYCLES, 12500000: idle cycles after a command completes.
- DEBOUNCE_CYCLES, 250000: stable cycles required on a button (10 ms).

Ports:
- clk  input  1  system clock, 25 MHz.
- rst  input  1  synchronous, active-high reset.
- scanEnable  input  1  arms automatic scanning while high.
- pushBtn  input  4  raw buttons; bit0 = pushBtn1.
- toneDir  input  3  result from ToneDetection.
- enableToneDetection  output  1  enable to ToneDetection.
- cmdDir  output  3  direction command.
- cmdValid  output  1  command valid.
- cmdReady  input  1  drive logic accepts the command.
- busy  output  1  high in any state other than IDLE.
- noTone  output  1  one-cycle pulse when a scan ends without consensus.

Behaviour:
- Direction codes:
  - 0 = none/stop, 1 = fwd, 2 = left, 3 = right, 4 = back.
  - toneDir values 5-7 are treated as 0.
- Reset:
  - State IDLE.
  - All outputs 0.
  - Counters, vote register and pending-manual register cleared.
  - Debouncers reset to released.
- All outputs are registered.
- States: IDLE, WINDOW, GAP, ISSUE, COOLDOWN.
- IDLE:
  - Pending manual command present -> ISSUE with that direction.
  - Else scanEnable=1 -> WINDOW; enableToneDetection=1 from the next cycle.
  - Window and vote counters are cleared on entry.
- WINDOW:
  - enableToneDetection held high for exactly WINDOW_CYCLES cycles.
  - toneDir is sampled on the last of those cycles.
- Sample evaluation:
  - Sample s nonzero and equal to the previous sample: agree++.
  - s nonzero otherwise: agree=1, previous=s.
  - s=0: agree=0.
  - agree reaches VOTE_COUNT: -> ISSUE with cmdDir=s.
  - Else windowsUsed++; if it reaches MAX_WINDOWS: -> ISSUE with cmdDir=0 and pulse noTone; else -> GAP.
- GAP: one cycle with enableToneDetection=0, then WINDOW.
- ISSUE:
  - cmdValid=1 with cmdDir stable until the cycle where cmdValid&&cmdReady.
  - Next cycle: cmdValid=0 and state COOLDOWN.
  - scanEnable dropping does not withdraw cmdValid.
  - A manual press during ISSUE is stored as pending; it never alters the in-flight command.
- COOLDOWN: COOLDOWN_CYCLES cycles, then IDLE.
- scanEnable=0 during WINDOW/GAP:
  - Abort to IDLE next cycle.
  - enableToneDetection=0; no command and no noTone pulse.
- Manual override:
  - Each button is debounced; a press is the 0->1 edge of the debounced level (one-cycle event).
  - Map: btn1=fwd, btn2=left, btn3=right, btn4=back.
  - Simultaneous presses: lowest index wins.
  - Press in IDLE, WINDOW, GAP or COOLDOWN: abort the current activity; enableToneDetection=0 next cycle; -> ISSUE with the mapped direction next cycle.
  - Pending register is single-entry; a newer press overwrites it.
  - Works with scanEnable=0.
- Latency:
  - scanEnable sampled high in IDLE at cycle 0 -> enableToneDetection high at cycle 1.
  - Press edge at cycle n -> cmdValid at cycle n+1 (cycle n+2 if the edge falls during COOLDOWN).
- rst mid-operation: all state returns to reset values on the next edge; a command in flight is dropped.

Decomposition:
- Shared package holds:
  - direction code constants (DIR_NONE, DIR_FWD, DIR_LEFT, DIR_RIGHT, DIR_BACK);
  - state encodings;
  - the button-to-direction map.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES), instantiated four times.
- btn_debounce outputs the debounced level and a rise pulse.

Test Plan (WINDOW_CYCLES=8, VOTE_COUNT=3, MAX_WINDOWS=4, COOLDOWN_CYCLES=5, DEBOUNCE_CYCLES=4):
- Consensus: scanEnable=1 at cycle 0, toneDir=2 constant -> enableToneDetection high cycles 1-8, 10-17 and 19-26, low at cycles 9 and 18; cmdValid=1 and cmdDir=2 at cycle 27.
- No consensus: toneDir alternating 1,3 per window -> after 4 windows, cmdDir=0 with cmdValid=1 and a single-cycle noTone.
- Backpressure: cmdReady=0 for 10 cycles -> cmdValid and cmdDir stable throughout; deassert the cycle after cmdReady=1; busy stays high through 5 cooldown cycles.
- Manual pre-emption: pushBtn[2] held 6 cycles mid-WINDOW -> debounced edge; enable low next cycle; cmdDir=3 and cmdValid next cycle; a 2-cycle glitch gives no command.
- Abort/overwrite: scanEnable dropped mid-WINDOW -> IDLE with no command. Presses btn1 then btn4 during ISSUE -> after handshake, the next command is 4.
- Reset: rst asserted during ISSUE -> next cycle all outputs 0 and busy=0; toneDir 6 sampled is treated as 0.
